// File: rtl/pes_demux_pkg.sv
// ---------------------------------------------------------------------------
// pes_demux_pkg
// Shared constants for the 1-to-4 demux consumer blocks.
//   NUM_CH / CH_IDX_W : channel count and channel index width
//   CNT_W_DEF         : default per-channel counter width
//   IDLE/CAPT/ACK     : read-FSM state encoding
//   top_idx()         : index of the highest set bit of a channel vector
// ---------------------------------------------------------------------------
package pes_demux_pkg;

    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned CH_IDX_W  = 2;
    localparam int unsigned CNT_W_DEF = 8;

    typedef logic [1:0] rd_state_t;

    localparam rd_state_t IDLE = 2'd0;
    localparam rd_state_t CAPT = 2'd1;
    localparam rd_state_t ACK  = 2'd2;

    // Highest-index set bit wins; returns 0 for an all-zero vector.
    function automatic logic [CH_IDX_W-1:0] top_idx(input logic [NUM_CH-1:0] v);
        logic [CH_IDX_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (v[k]) begin
                idx = CH_IDX_W'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pes_sat_counter.sv
// ---------------------------------------------------------------------------
// pes_sat_counter
// One saturating event counter with a sticky overflow flag.
// Ports:
//   clk    : clock
//   reset  : asynchronous active-high reset
//   inc    : count one event this cycle
//   clr    : synchronous clear of count and overflow (highest priority)
//   rd_clr : clear-on-read; the same-cycle event (if any) is kept as a count of 1
//   cnt    : current count
//   ovf    : sticky flag, set when an event arrives while the count is at maximum
// ---------------------------------------------------------------------------
module pes_sat_counter
    import pes_demux_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    input  logic             rd_clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic at_max;

    assign at_max = &cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (rd_clr) begin
            // An event landing in the clearing cycle must not be lost.
            cnt <= inc ? CNT_W'(1) : '0;
            ovf <= 1'b0;
        end else if (inc) begin
            if (at_max) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pes_4ch_event_counter.sv
// ---------------------------------------------------------------------------
// pes_4ch_event_counter
// Counts rising edges on the four demux outputs in saturating counters,
// tracks the most recently active channel and serves counts to a host over a
// four-phase req/ack read handshake.
// Ports:
//   clk       : clock, all state changes on its rising edge
//   reset     : asynchronous active-high reset
//   ch_in     : demux outputs {o3,o2,o1,o0}, synchronous to clk
//   clr       : synchronous clear of all counters and overflow flags
//   rd_req    : read request (four-phase)
//   rd_ch     : channel to read, sampled only when a request is accepted
//   rd_ack    : read acknowledge; rd_data valid while high
//   rd_data   : captured count of the requested channel
//   active_ch : channel that most recently saw a rising edge
//   ovf       : sticky per-channel saturation flags
// Build option:
//   PES_CNT_CLR_ON_READ_EN : when defined, a read also clears the read channel's
//                            counter and overflow flag (destructive read).
// ---------------------------------------------------------------------------
module pes_4ch_event_counter
    import pes_demux_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   ch_in,
    input  logic                clr,
    input  logic                rd_req,
    input  logic [CH_IDX_W-1:0] rd_ch,
    output logic                rd_ack,
    output logic [CNT_W-1:0]    rd_data,
    output logic [CH_IDX_W-1:0] active_ch,
    output logic [NUM_CH-1:0]   ovf
);

    logic [NUM_CH-1:0]   ch_prev_q;
    logic [NUM_CH-1:0]   ch_edge;
    logic [NUM_CH-1:0]   rd_clr;
    logic [CNT_W-1:0]    cnt [NUM_CH];

    rd_state_t           state_q;
    rd_state_t           state_d;
    logic [CH_IDX_W-1:0] ch_l_q;
    logic [CNT_W-1:0]    rd_data_q;
    logic [CH_IDX_W-1:0] active_ch_q;

    // ------------------------------------------------------------------
    // Edge detection; ch_prev resets to 0 so a line already high at reset
    // release counts as one event.
    // ------------------------------------------------------------------
    assign ch_edge = ch_in & ~ch_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_prev_q <= '0;
        end else begin
            ch_prev_q <= ch_in;
        end
    end

    // ------------------------------------------------------------------
    // Most recent channel: highest index among simultaneous edges.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_ch_q <= '0;
        end else if (|ch_edge) begin
            active_ch_q <= top_idx(ch_edge);
        end
    end

    assign active_ch = active_ch_q;

    // ------------------------------------------------------------------
    // Per-channel counters
    // ------------------------------------------------------------------
`ifdef PES_CNT_CLR_ON_READ_EN
    always_comb begin
        rd_clr = '0;
        if (state_q == CAPT) begin
            rd_clr[ch_l_q] = 1'b1;
        end
    end
`else
    always_comb begin
        rd_clr = '0;
    end
`endif

    for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt
        pes_sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk    (clk),
            .reset  (reset),
            .inc    (ch_edge[k]),
            .clr    (clr),
            .rd_clr (rd_clr[k]),
            .cnt    (cnt[k]),
            .ovf    (ovf[k])
        );
    end

    // ------------------------------------------------------------------
    // Read FSM. ACK only exits on rd_req low, so a request held high across
    // the return to IDLE can never restart a read without a low phase.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rd_req) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                state_d = ACK;
            end
            ACK: begin
                if (!rd_req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ch_l_q    <= '0;
            rd_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && rd_req) begin
                ch_l_q <= rd_ch;
            end
            // Captures the pre-increment register value of this cycle.
            if (state_q == CAPT) begin
                rd_data_q <= cnt[ch_l_q];
            end
        end
    end

    assign rd_ack  = (state_q == ACK);
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_pes_4ch_event_counter.sv
// ---------------------------------------------------------------------------
// tb_pes_4ch_event_counter
// Directed scenarios followed by randomized traffic. A reference model keeps
// per-channel event counts as plain integers; reads push the expected count
// into a queue and a monitor pops and compares on each rd_ack rising edge.
// ---------------------------------------------------------------------------
module tb_pes_4ch_event_counter;

    localparam int CNT_W = 4;
    localparam int MAXV  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       ch_in;
    logic             clr;
    logic             rd_req;
    logic [1:0]       rd_ch;
    logic             rd_ack;
    logic [CNT_W-1:0] rd_data;
    logic [1:0]       active_ch;
    logic [3:0]       ovf;

    pes_4ch_event_counter #(
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ch_in     (ch_in),
        .clr       (clr),
        .rd_req    (rd_req),
        .rd_ch     (rd_ch),
        .rd_ack    (rd_ack),
        .rd_data   (rd_data),
        .active_ch (active_ch),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int         mcnt [4];
    logic [3:0] movf;
    logic [3:0] mprev;
    logic [1:0] mact;
    int         rdclr = -1;
    int         exp_q [$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) mcnt[k] = 0;
        movf  = '0;
        mprev = '0;
        mact  = '0;
        rdclr = -1;
    endtask

    // Apply the counting rules for the coming clock edge.
    task automatic model_edge();
        logic [3:0] e;
        e = ch_in & ~mprev;
        for (int k = 0; k < 4; k++) begin
            if (clr) begin
                mcnt[k] = 0;
                movf[k] = 1'b0;
            end else if (rdclr == k) begin
                mcnt[k] = e[k] ? 1 : 0;
                movf[k] = 1'b0;
            end else if (e[k]) begin
                if (mcnt[k] == MAXV) movf[k] = 1'b1;
                else                 mcnt[k] = mcnt[k] + 1;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (e[k]) mact = 2'(k);
        end
        mprev = ch_in;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("ovf", int'(ovf), int'(movf));
        check("active_ch", int'(active_ch), int'(mact));
    endtask

    task automatic apply_reset();
        reset  = 1'b1;
        ch_in  = '0;
        clr    = 1'b0;
        rd_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    // Full four-phase read. capt_or is ORed into ch_in during the capture cycle.
    task automatic do_read(input int c, input logic [3:0] capt_or, input bit rnd);
        rd_req = 1'b1;
        rd_ch  = 2'(c);
        if (rnd) ch_in = 4'($urandom);
        step();
        check("ack_early", int'(rd_ack), 0);
        rd_ch = 2'($urandom);
        if (rnd) ch_in = 4'($urandom);
        ch_in = ch_in | capt_or;
        exp_q.push_back(mcnt[c]);
`ifdef PES_CNT_CLR_ON_READ_EN
        rdclr = c;
`endif
        step();
        rdclr = -1;
        check("ack_latency", int'(rd_ack), 1);
        repeat ($urandom_range(0, 2)) begin
            if (rnd) ch_in = 4'($urandom);
            step();
            check("ack_hold", int'(rd_ack), 1);
        end
        rd_req = 1'b0;
        if (rnd) ch_in = 4'($urandom);
        step();
        check("ack_drop", int'(rd_ack), 0);
    endtask

    // Scoreboard monitor
    logic ack_prev = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            ack_prev = 1'b0;
        end else begin
            if (rd_ack && !ack_prev) begin
                if (exp_q.size() == 0) begin
                    check("rd_unexpected", 1, 0);
                end else begin
                    check("rd_data", int'(rd_data), exp_q.pop_front());
                end
            end
            ack_prev = rd_ack;
        end
    end

    initial begin
        reset  = 1'b1;
        ch_in  = '0;
        clr    = 1'b0;
        rd_req = 1'b0;
        rd_ch  = '0;
        model_reset();
        #1;
        check("rst_rd_ack", int'(rd_ack), 0);
        check("rst_rd_data", int'(rd_data), 0);
        apply_reset();

        // Idle after reset
        repeat (10) step();
        check("idle_rd_ack", int'(rd_ack), 0);
        for (int c = 0; c < 4; c++) do_read(c, 4'b0000, 1'b0);

        // Five pulses on ch2
        for (int r = 0; r < 5; r++) begin
            ch_in[2] = 1'b1;
            repeat (3) step();
            ch_in[2] = 1'b0;
            repeat (2) step();
        end
        for (int c = 0; c < 4; c++) do_read(c, 4'b0000, 1'b0);

        // Simultaneous edges on ch1 and ch3
        ch_in = 4'b1010;
        step();
        check("active_ch_multi", int'(active_ch), 3);
        do_read(1, 4'b0000, 1'b0);
        do_read(3, 4'b0000, 1'b0);
        ch_in = 4'b0000;
        step();

        // Saturation on ch0, then clr colliding with an edge
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int r = 0; r < 17; r++) begin
            ch_in[0] = 1'b1;
            step();
            ch_in[0] = 1'b0;
            step();
        end
        check("ovf0_sat", int'(ovf[0]), 1);
        do_read(0, 4'b0000, 1'b0);
        ch_in = 4'b0001;
        clr   = 1'b1;
        step();
        clr   = 1'b0;
        check("ovf0_clr", int'(ovf[0]), 0);
        do_read(0, 4'b0000, 1'b0);
        ch_in = 4'b0000;
        step();

        // Reset while acknowledging
        for (int r = 0; r < 3; r++) begin
            ch_in[0] = 1'b1;
            step();
            ch_in[0] = 1'b0;
            step();
        end
        rd_req = 1'b1;
        rd_ch  = 2'd0;
        step();
        exp_q.push_back(mcnt[0]);
`ifdef PES_CNT_CLR_ON_READ_EN
        rdclr = 0;
`endif
        step();
        rdclr = -1;
        check("ack_before_rst", int'(rd_ack), 1);
        #6;
        reset = 1'b1;
        #1;
        check("ack_async_rst", int'(rd_ack), 0);
        apply_reset();
        do_read(0, 4'b0000, 1'b0);

        // Seven events on ch1, then a read whose capture cycle sees another edge
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int r = 0; r < 7; r++) begin
            ch_in[1] = 1'b1;
            step();
            ch_in[1] = 1'b0;
            step();
        end
        do_read(1, 4'b0010, 1'b0);
        ch_in = 4'b0000;
        step();
        do_read(1, 4'b0000, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                do_read(int'($urandom_range(0, 3)), 4'b0000, 1'b1);
            end else begin
                ch_in = 4'($urandom);
                clr   = ($urandom_range(0, 24) == 0);
                step();
                clr   = 1'b0;
            end
        end

        repeat (3) step();
        check("scoreboard_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
